// File: rtl/calc_seq_ctrl_if.sv
// Bundle between the calculator sequencer and its key/ALU/display neighbours.
// Latency: none, wires only.
// Backpressure: none; every strobe is a single-cycle, unacknowledged event.
interface calc_seq_ctrl_if #(
   parameter int OPW  = 7,
   parameter int RESW = 14
);
   logic            key_valid;
   logic [3:0]      key_code;
   logic            alu_start;
   logic [OPW-1:0]  alu_a;
   logic [OPW-1:0]  alu_b;
   logic [1:0]      alu_op;
   logic            alu_done;
   logic [RESW-1:0] alu_result;
   logic            alu_neg;
   logic            alu_err;
   logic [RESW-1:0] disp_val;
   logic            disp_neg;
   logic            disp_err;
   logic            disp_blank;
   logic            busy;
   logic [3:0]      state;

   // Sequencer side
   modport master (
      input  key_valid, key_code, alu_done, alu_result, alu_neg, alu_err,
      output alu_start, alu_a, alu_b, alu_op,
      output disp_val, disp_neg, disp_err, disp_blank, busy, state
   );

   // Keyboard / ALU / display side
   modport slave (
      output key_valid, key_code, alu_done, alu_result, alu_neg, alu_err,
      input  alu_start, alu_a, alu_b, alu_op,
      input  disp_val, disp_neg, disp_err, disp_blank, busy, state
   );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator key sequencer: builds operand A, operator, operand B, launches the ALU, drives display regs.
// Latency: a key or alu_done sampled at an edge is reflected in all registered outputs after that edge.
// Backpressure: none; keys other than C are dropped while busy. CALC_CHAIN_EN lets an operator in DONE reuse the result.
module calc_seq_ctrl #(
   parameter int NUM_DIG = 2,
   parameter int OPW     = 7,
   parameter int RESW    = 14
) (
   input  logic            clk,
   input  logic            rst_n,
   calc_seq_ctrl_if.master ctl
);
   localparam int         ACC_W   = OPW + 4;
   localparam logic [1:0] CNT_MAX = 2'(NUM_DIG);
`ifdef CALC_CHAIN_EN
   localparam logic [RESW-1:0] MAX_OPND = RESW'((NUM_DIG == 1) ? 9 : ((NUM_DIG == 2) ? 99 : 999));
`endif

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      A_ENT = 4'd1,
      OP    = 4'd2,
      B_ENT = 4'd3,
      CALC  = 4'd4,
      DONE  = 4'd5,
      ERR   = 4'd6
   } state_e;

   state_e          state_q, state_d;
   logic [OPW-1:0]  a_q, a_d, b_q, b_d;
   logic [1:0]      op_q, op_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            clr_pend_q, clr_pend_d;
   logic            start_q, start_d;
   logic [RESW-1:0] val_q, val_d;
   logic            neg_q, neg_d, err_q, err_d, blank_q, blank_d;

   logic            is_dig, is_op, is_eq, is_clr, do_clr;
   logic [1:0]      key_op;
   logic [OPW-1:0]  acc_a, acc_b, dig_v;

   assign is_dig = ctl.key_valid && (ctl.key_code <= 4'd9);
   assign is_op  = ctl.key_valid && (ctl.key_code >= 4'ha) && (ctl.key_code <= 4'hd);
   assign is_eq  = ctl.key_valid && (ctl.key_code == 4'he);
   assign is_clr = ctl.key_valid && (ctl.key_code == 4'hf);
   // a..d map to 0..3; subtracting 2 in two bits equals key_code - 4'ha for those codes
   assign key_op = ctl.key_code[1:0] - 2'd2;
   assign dig_v  = OPW'(ctl.key_code);
   // Widened multiply-add; the digit cap keeps the value inside OPW bits
   assign acc_a  = OPW'(({4'b0000, a_q} * ACC_W'(10)) + ACC_W'(ctl.key_code));
   assign acc_b  = OPW'(({4'b0000, b_q} * ACC_W'(10)) + ACC_W'(ctl.key_code));

   // Next-state and register updates for every key / completion event
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      clr_pend_d = clr_pend_q;
      start_d    = 1'b0;
      val_d      = val_q;
      neg_d      = neg_q;
      err_d      = err_q;
      blank_d    = blank_q;
      do_clr     = is_clr && (state_q != CALC);
      case (state_q)
         IDLE: if (is_dig) begin
            a_d     = dig_v;
            cnt_d   = 2'd1;
            val_d   = RESW'(ctl.key_code);
            blank_d = 1'b0;
            state_d = A_ENT;
         end
         A_ENT: begin
            if (is_dig && (cnt_q < CNT_MAX)) begin
               a_d   = acc_a;
               cnt_d = cnt_q + 2'd1;
               val_d = RESW'(acc_a);
            end else if (is_op) begin
               op_d    = key_op;
               state_d = OP;
            end
         end
         OP: begin
            if (is_dig) begin
               b_d     = dig_v;
               cnt_d   = 2'd1;
               val_d   = RESW'(ctl.key_code);
               state_d = B_ENT;
            end else if (is_op) begin
               op_d = key_op;
            end
         end
         B_ENT: begin
            if (is_dig && (cnt_q < CNT_MAX)) begin
               b_d   = acc_b;
               cnt_d = cnt_q + 2'd1;
               val_d = RESW'(acc_b);
            end else if (is_eq) begin
               start_d = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (is_clr) clr_pend_d = 1'b1;
            if (ctl.alu_done) begin
               clr_pend_d = 1'b0;
               if (clr_pend_q || is_clr) begin
                  do_clr = 1'b1;
               end else if (ctl.alu_err) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else begin
                  val_d   = ctl.alu_result;
                  neg_d   = ctl.alu_neg;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (is_dig) begin
               a_d     = dig_v;
               cnt_d   = 2'd1;
               neg_d   = 1'b0;
               val_d   = RESW'(ctl.key_code);
               state_d = A_ENT;
            end
`ifdef CALC_CHAIN_EN
            else if (is_op && !neg_q && (val_q <= MAX_OPND)) begin
               a_d     = OPW'(val_q);
               op_d    = key_op;
               state_d = OP;
            end
`endif
         end
         ERR:     ;
         default: state_d = IDLE;
      endcase
      if (do_clr) begin
         state_d    = IDLE;
         a_d        = '0;
         b_d        = '0;
         op_d       = '0;
         cnt_d      = '0;
         clr_pend_d = 1'b0;
         val_d      = '0;
         neg_d      = 1'b0;
         err_d      = 1'b0;
         blank_d    = 1'b1;
      end
   end

   // State and output registers with asynchronous clear to the idle/blank display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         clr_pend_q <= 1'b0;
         start_q    <= 1'b0;
         val_q      <= '0;
         neg_q      <= 1'b0;
         err_q      <= 1'b0;
         blank_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         clr_pend_q <= clr_pend_d;
         start_q    <= start_d;
         val_q      <= val_d;
         neg_q      <= neg_d;
         err_q      <= err_d;
         blank_q    <= blank_d;
      end
   end

   assign ctl.alu_start  = start_q;
   assign ctl.alu_a      = a_q;
   assign ctl.alu_b      = b_q;
   assign ctl.alu_op     = op_q;
   assign ctl.disp_val   = val_q;
   assign ctl.disp_neg   = neg_q;
   assign ctl.disp_err   = err_q;
   assign ctl.disp_blank = blank_q;
   assign ctl.busy       = (state_q == CALC);
   assign ctl.state      = state_q;
endmodule
